// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN training datapath: loader FSM state
// encoding and the byte-to-fixed-point pixel conversion.
package cnn_pkg;

  typedef enum logic [1:0] {
    FILL_LABEL,
    FILL_PIXELS,
    FULL
  } loader_state_t;

  localparam int PIXEL_BITS = 8;

  // Widest fixed-point word the helper produces; callers keep the low WIDTH bits.
  localparam int MAX_FIXED_WIDTH = 64;

  // Places an unsigned pixel byte so that 255 maps to 255/256 in a format
  // with frac_bits fractional bits. The byte is zero-extended, so the
  // result is never negative.
  function automatic logic signed [MAX_FIXED_WIDTH-1:0] pixel_to_fixed(
    input logic [PIXEL_BITS-1:0] pix,
    input int                    frac_bits
  );
    logic [MAX_FIXED_WIDTH-1:0] ext;
    ext = {{(MAX_FIXED_WIDTH-PIXEL_BITS){1'b0}}, pix};
    return signed'(ext << (frac_bits - PIXEL_BITS));
  endfunction

endpackage

// File: rtl/image_stream_loader.sv
// Byte-stream image loader: assembles label + row-major pixels into a back
// buffer and swaps it into a stable front buffer when the network is done
// with the current image.
//
// state       | meaning
// ------------|-------------------------------------------------------------
// FILL_LABEL  | waiting for the label byte of the next image
// FILL_PIXELS | writing pixel bytes into back[row][col], row-major
// FULL        | back buffer complete, no accepts until it is swapped to front
module image_stream_loader
  import cnn_pkg::*;
#(
  parameter int WIDTH             = 32,
  parameter int FIXED_POINT_INDEX = 16,
  parameter int INPUT_DIM_HEIGHT  = 28,
  parameter int INPUT_DIM_WIDTH   = 28,
  parameter int NUM_CLASSES       = 10,
  parameter int NUM_IMAGES        = 10000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [PIXEL_BITS-1:0]           s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic                            consume,
  output logic signed [WIDTH-1:0]         image_data [INPUT_DIM_HEIGHT][INPUT_DIM_WIDTH],
  output logic [WIDTH-1:0]                image_labels [NUM_CLASSES],
  output logic                            frame_valid,
  output logic [$clog2(NUM_IMAGES)-1:0]   image_count,
  output logic                            label_error
);

  localparam int RW  = (INPUT_DIM_HEIGHT > 1) ? $clog2(INPUT_DIM_HEIGHT) : 1;
  localparam int CW  = (INPUT_DIM_WIDTH > 1) ? $clog2(INPUT_DIM_WIDTH) : 1;
  localparam int NCW = $clog2(NUM_IMAGES);

  loader_state_t state, state_next;

  logic signed [WIDTH-1:0] back_data [INPUT_DIM_HEIGHT][INPUT_DIM_WIDTH];
  logic [WIDTH-1:0]        back_labels [NUM_CLASSES];

  logic          back_full;
  logic          front_valid;
  logic [RW-1:0] row;
  logic [CW-1:0] col;

  logic accept;
  logic swap;
  logic last_pixel;
  logic signed [MAX_FIXED_WIDTH-1:0] pixel_wide;
  logic signed [WIDTH-1:0]           pixel_fixed;

  // Ready is held low during reset even though back_full is already clear.
  assign s_ready     = reset && !back_full;
  assign accept      = s_valid && s_ready;
  assign swap        = back_full && (!front_valid || consume);
  assign last_pixel  = (row == RW'(INPUT_DIM_HEIGHT-1)) && (col == CW'(INPUT_DIM_WIDTH-1));
  assign frame_valid = front_valid;
  assign pixel_wide  = pixel_to_fixed(s_data, FIXED_POINT_INDEX);
  assign pixel_fixed = pixel_wide[WIDTH-1:0];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL_LABEL;
    else        state <= state_next;
  end

  // Next-state logic for the back-buffer fill sequence.
  always_comb begin
    state_next = state;
    case (state)
      FILL_LABEL:  if (accept) state_next = FILL_PIXELS;
      FILL_PIXELS: if (accept && last_pixel) state_next = FULL;
      FULL:        if (swap) state_next = FILL_LABEL;
      default:     state_next = FILL_LABEL;
    endcase
  end

  // Buffer ownership flags, fill counters, image counter and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      back_full   <= 1'b0;
      front_valid <= 1'b0;
      row         <= '0;
      col         <= '0;
      image_count <= '0;
      label_error <= 1'b0;
    end else begin
      if (swap) begin
        back_full   <= 1'b0;
        front_valid <= 1'b1;
        if (image_count == NCW'(NUM_IMAGES-1)) image_count <= '0;
        else                                   image_count <= image_count + 1'b1;
      end else if (consume && front_valid) begin
        // Front contents are left in place; only the valid flag drops.
        front_valid <= 1'b0;
      end
      if (accept) begin
        if (state == FILL_LABEL) begin
          if (int'(s_data) >= NUM_CLASSES) label_error <= 1'b1;
        end else if (state == FILL_PIXELS) begin
          if (last_pixel) begin
            back_full <= 1'b1;
            row       <= '0;
            col       <= '0;
          end else if (col == CW'(INPUT_DIM_WIDTH-1)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
    end
  end

  // Back buffer: label decode and pixel writes as bytes arrive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < INPUT_DIM_HEIGHT; r++)
        for (int c = 0; c < INPUT_DIM_WIDTH; c++)
          back_data[r][c] <= '0;
      for (int i = 0; i < NUM_CLASSES; i++)
        back_labels[i] <= '0;
    end else if (accept) begin
      if (state == FILL_LABEL) begin
        for (int i = 0; i < NUM_CLASSES; i++)
          back_labels[i] <= (int'(s_data) == i) ? WIDTH'(1) : '0;
      end else if (state == FILL_PIXELS) begin
        back_data[row][col] <= pixel_fixed;
      end
    end
  end

  // Front buffer changes only on a swap, so the network sees a stable frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < INPUT_DIM_HEIGHT; r++)
        for (int c = 0; c < INPUT_DIM_WIDTH; c++)
          image_data[r][c] <= '0;
      for (int i = 0; i < NUM_CLASSES; i++)
        image_labels[i] <= '0;
    end else if (swap) begin
      image_data   <= back_data;
      image_labels <= back_labels;
    end
  end

endmodule

// File: tb/tb_image_stream_loader.sv
// Directed bench for image_stream_loader: image-level reference model checked
// every cycle, plus literal spot checks at key points.
module tb_image_stream_loader;
  localparam int W  = 32;
  localparam int H  = 28;
  localparam int WD = 28;
  localparam int NC = 10;
  localparam int NI = 5;
  localparam int NPIX = H * WD;

  logic                 clk;
  logic                 reset;
  logic [7:0]           s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic                 consume;
  logic signed [W-1:0]  image_data [H][WD];
  logic [W-1:0]         image_labels [NC];
  logic                 frame_valid;
  logic [$clog2(NI)-1:0] image_count;
  logic                 label_error;

  int total = 0;
  int bad   = 0;

  image_stream_loader #(
    .WIDTH(W), .FIXED_POINT_INDEX(16), .INPUT_DIM_HEIGHT(H),
    .INPUT_DIM_WIDTH(WD), .NUM_CLASSES(NC), .NUM_IMAGES(NI)
  ) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .consume(consume), .image_data(image_data),
    .image_labels(image_labels), .frame_valid(frame_valid),
    .image_count(image_count), .label_error(label_error)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Image-level reference model.
  int m_pos, m_back_label, m_front_label, m_count;
  bit m_bfull, m_fvalid, m_err;
  int m_back_pix [NPIX];
  int m_front_pix [NPIX];

  always @(posedge clk or negedge reset) begin
    bit acc, sw;
    if (!reset) begin
      m_pos = 0; m_bfull = 0; m_fvalid = 0; m_err = 0; m_count = 0;
      m_back_label = -1; m_front_label = -1;
      for (int i = 0; i < NPIX; i++) begin m_back_pix[i] = 0; m_front_pix[i] = 0; end
    end else begin
      acc = s_valid && !m_bfull;
      sw  = m_bfull && (!m_fvalid || consume);
      if (sw) begin
        m_front_label = m_back_label;
        m_front_pix   = m_back_pix;
        m_fvalid = 1; m_bfull = 0;
        m_count  = (m_count + 1) % NI;
      end else if (consume && m_fvalid) begin
        m_fvalid = 0;
      end
      if (acc) begin
        if (m_pos == 0) begin
          m_back_label = int'(s_data);
          if (int'(s_data) >= NC) m_err = 1;
        end else begin
          m_back_pix[m_pos-1] = int'(s_data);
        end
        m_pos++;
        if (m_pos == NPIX + 1) begin m_pos = 0; m_bfull = 1; end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    int first_bad;
    check("s_ready", 64'(s_ready), 64'(reset && !m_bfull));
    check("frame_valid", 64'(frame_valid), 64'(m_fvalid));
    check("image_count", 64'(image_count), 64'(m_count));
    check("label_error", 64'(label_error), 64'(m_err));
    for (int i = 0; i < NC; i++)
      check("image_labels", 64'(image_labels[i]), (m_front_label == i) ? 64'd1 : 64'd0);
    first_bad = -1;
    for (int i = 0; i < NPIX; i++)
      if (image_data[i / WD][i % WD] !== W'(m_front_pix[i] * 256) && first_bad < 0) first_bad = i;
    total++;
    if (first_bad >= 0) begin
      bad++;
      $display("FAIL image_data idx=%0d got=%0h exp=%0h at %0t", first_bad,
               image_data[first_bad / WD][first_bad % WD], W'(m_front_pix[first_bad] * 256), $time);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Offers one byte and waits (bounded) until it is taken.
  task automatic push(input logic [7:0] b, input bit gaps, input bit consume_with);
    int cnt;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin s_valid = 0; step(1); end
    end
    s_data = b; s_valid = 1; cnt = 0;
    while (!s_ready && cnt < 3000) begin step(1); cnt++; end
    if (cnt >= 3000) begin
      total++; bad++;
      $display("FAIL push_timeout byte=%0h", b);
    end
    if (consume_with) consume = 1;
    step(1);
    consume = 0;
  endtask

  function automatic logic [7:0] pv(input int i, input int mul, input int add);
    return 8'((i * mul + add) % 256);
  endfunction

  task automatic send_image(input int label, input int mul, input int add,
                            input int npix, input bit gaps, input bit consume_last);
    push(8'(label), gaps, 0);
    for (int i = 0; i < npix; i++)
      push(pv(i, mul, add), gaps, consume_last && (i == NPIX - 1));
    s_valid = 0;
  endtask

  task automatic pulse_consume();
    consume = 1; step(1); consume = 0;
  endtask

  initial begin
    reset = 0; s_data = 0; s_valid = 0; consume = 0;
    step(3);
    check("reset_ready", 64'(s_ready), 64'd0);
    check("reset_frame_valid", 64'(frame_valid), 64'd0);
    reset = 1;
    step(2);

    // Image A: label 3, pixels i mod 256.
    send_image(3, 1, 0, NPIX, 0, 0);
    step(1);
    check("a_frame_valid", 64'(frame_valid), 64'd1);
    check("a_label3", 64'(image_labels[3]), 64'd1);
    check("a_label0", 64'(image_labels[0]), 64'd0);
    check("a_count", 64'(image_count), 64'd1);
    check("a_px_0_1", 64'(image_data[0][1]), 64'h100);
    check("a_px_27_27", 64'(image_data[27][27]), 64'hF00);

    // Image B fills back while front holds A.
    send_image(7, 7, 1, NPIX, 0, 0);
    step(3);
    check("b_full_ready", 64'(s_ready), 64'd0);
    check("b_front_still_a", 64'(image_data[0][0]), 64'h0);
    pulse_consume();
    check("b_count", 64'(image_count), 64'd2);
    check("b_px_0_0", 64'(image_data[0][0]), 64'h100);
    check("b_label7", 64'(image_labels[7]), 64'd1);
    check("b_ready_again", 64'(s_ready), 64'd1);

    // Image C: consume lands on the last-pixel edge.
    send_image(0, 3, 2, NPIX, 0, 1);
    check("c_gap", 64'(frame_valid), 64'd0);
    step(1);
    check("c_valid", 64'(frame_valid), 64'd1);
    check("c_count", 64'(image_count), 64'd3);
    check("c_px_0_0", 64'(image_data[0][0]), 64'h200);

    // Image D: out-of-range label 12 with a bursty source.
    send_image(12, 13, 5, NPIX, 1, 0);
    step(2);
    pulse_consume();
    check("d_error", 64'(label_error), 64'd1);
    check("d_count", 64'(image_count), 64'd4);
    check("d_label0", 64'(image_labels[0]), 64'd0);

    // Image E: count wraps NI-1 -> 0, error remains sticky.
    send_image(5, 11, 9, NPIX, 0, 0);
    step(1);
    pulse_consume();
    check("e_wrap", 64'(image_count), 64'd0);
    check("e_error_sticky", 64'(label_error), 64'd1);
    check("e_label5", 64'(image_labels[5]), 64'd1);

    // Image F, then partial G interrupted by reset.
    send_image(2, 5, 0, NPIX, 0, 0);
    step(1);
    pulse_consume();
    check("f_count", 64'(image_count), 64'd1);
    send_image(4, 1, 7, 100, 0, 0);
    reset = 0;
    #1;
    check("rst_frame_valid", 64'(frame_valid), 64'd0);
    check("rst_ready", 64'(s_ready), 64'd0);
    check("rst_count", 64'(image_count), 64'd0);
    check("rst_error", 64'(label_error), 64'd0);
    check("rst_px", 64'(image_data[27][27]), 64'd0);
    check("rst_label2", 64'(image_labels[2]), 64'd0);
    step(2);
    reset = 1;
    step(1);

    // Image H after reset.
    send_image(9, 1, 0, NPIX, 0, 0);
    step(2);
    check("h_valid", 64'(frame_valid), 64'd1);
    check("h_count", 64'(image_count), 64'd1);
    check("h_label9", 64'(image_labels[9]), 64'd1);
    check("h_px_27_27", 64'(image_data[27][27]), 64'hF00);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/image_stream_loader.md
Name: image_stream_loader

Overview:
Upstream feeder for the CNN training top. It accepts a byte stream of labelled images over a valid/ready handshake. Each image is one label byte followed by 784 row-major pixel bytes. The block assembles each image into a double-buffered 28x28 fixed-point frame plus a one-hot label vector, holding them stable for the network. The next image is loaded in the background and swapped in when the network signals it has consumed the current one.

Parameters:
- WIDTH, 32, bit width of each output pixel/label word (signed fixed point).
- FIXED_POINT_INDEX, 16, fractional bits of the output format; must be >= 8.
- INPUT_DIM_HEIGHT, 28, image rows.
- INPUT_DIM_WIDTH, 28, image columns.
- NUM_CLASSES, 10, label vector length.
- NUM_IMAGES, 10000, dataset size; image_count wraps here.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- s_data  in  8  stream byte: label or pixel.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader can accept s_data this cycle.
- consume  in  1  single-cycle pulse from the network top: current front image used.
- image_data  out  WIDTH x [INPUT_DIM_HEIGHT][INPUT_DIM_WIDTH]  front-buffer pixels, signed fixed point.
- image_labels  out  WIDTH x [NUM_CLASSES]  front-buffer one-hot label, integer 1/0 (not fixed point).
- frame_valid  out  1  front buffer holds a complete image.
- image_count  out  $clog2(NUM_IMAGES)  number of images swapped to front, modulo NUM_IMAGES.
- label_error  out  1  sticky: a label byte >= NUM_CLASSES was received.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs and buffers clear to 0, state goes to FILL_LABEL, and back_full/front_valid clear to 0.
  - s_ready is 0 while reset is asserted.
- Transfer: a byte is accepted on a rising clk edge when s_valid && s_ready.
- s_ready = !back_full (registered flag). The block never stalls mid-image except when the back buffer is full.
- Back-buffer FSM states and transitions:
  - FILL_LABEL: on accept, decode the label into the back label vector and go to FILL_PIXELS.
    - Label L < NUM_CLASSES: element L = 1, all others 0.
    - Label >= NUM_CLASSES: all elements 0 and label_error set.
  - FILL_PIXELS: on accept, write the pixel to back[r][c] and advance a column counter c, then a row counter r (row-major).
    - When the byte at r = H-1, c = W-1 is accepted: set back_full, reset the counters, go to FULL.
  - FULL: no accepts; wait for a swap.
- Pixel conversion: zero-extend the byte to WIDTH, then shift left by (FIXED_POINT_INDEX-8). Range is [0, 255/256]; the result is never negative.
- Swap condition at a clock edge: back_full && (!front_valid || consume). On swap:
  - front <= back, front_valid <= 1, back_full <= 0, state <= FILL_LABEL.
  - image_count increments, wrapping from NUM_IMAGES-1 to 0.
- consume && front_valid && !back_full: front_valid <= 0. front contents are held (stale but stable).
- consume while front_valid = 0 is ignored.
- frame_valid = front_valid.
- Latency: last pixel accepted at edge N gives back_full = 1 after edge N. With front empty, the swap happens at edge N+1 and frame_valid = 1 after N+1. Minimum 1 cycle of s_ready = 0 between images.
- Simultaneous events:
  - consume on the same edge as the last pixel accept (back_full still 0): front_valid clears, and the swap occurs on the next edge.
  - consume while back_full: swap on that edge with no gap in frame_valid.
- The front buffer only changes on a swap, so image_data is stable for the entire network pass.
- Reset mid-image discards the partial image; the stream source must restart at a label byte.
- label_error clears only on reset.

Decomposition:
- Shared package cnn_pkg holds:
  - typedef loader_state_t {FILL_LABEL, FILL_PIXELS, FULL};
  - constant PIXEL_BITS = 8;
  - function pixel_to_fixed(byte) returning signed WIDTH.
- Sub-module: none. The double buffer, FSM and counters stay in image_stream_loader. pixel_to_fixed lives in the package rather than as a module.

Test Plan:
- Reset, then stream label 3 and pixels p[i] = i mod 256 with s_valid held high → after the last pixel plus 1 cycle:
  - frame_valid = 1, image_labels = {0,0,0,1,0,...}, image_count = 1.
  - image_data[0][1] = 0x00000100, image_data[27][27] = (783 mod 256) << 8 = 0x00000F00.
- Stream two images back to back with no consume → second image fills back and s_ready drops to 0 (FULL); front stays image 1. Pulse consume → front = image 2 on that edge, image_count = 2, s_ready = 1 next cycle.
- consume pulse on the exact edge the last pixel of image 2 is accepted → frame_valid = 0 for one cycle, then 1 with image 2.
- Label byte 12 → label_error = 1, image_labels all 0, image still swapped in. label_error stays 1 through later valid images.
- Randomly toggle s_valid during a fill → pixel order and values are unchanged versus a gap-free stream.
- Assert reset after 100 pixels → all outputs 0 immediately. After release, a full fresh image loads correctly and image_count wraps 9999→0 with NUM_IMAGES = 10000.
